// File: rtl/msrv32_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, runs the imem req/ack handshake,
// absorbs decode stalls with a one-entry skid buffer and kills fetches made stale by redirects.
module msrv32_fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        stall_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_addr_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_vector_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        misaligned_out
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BLOCK,
    MISALIGN
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic        req_reg, req_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc_reg, pc_next;
  logic        valid_reg, valid_next;
  logic        misaligned_reg, misaligned_next;
  logic        buf_valid_reg, buf_valid_next;
  logic [31:0] buf_instr_reg, buf_instr_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic        kill_reg, kill_next;

  logic        ack_fire;
  logic        consume;
  logic        take_redirect;
  logic        redirect_any;
  logic        mis_target;
  logic        go_block;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign ack_fire = req_reg && imem_ack_in;
  assign consume  = valid_reg && !stall_in;
  assign pc_plus4 = fetch_pc_reg + 32'd4;

  // A misaligned redirect parks the fetch unit; only a trap can move it out again.
  assign take_redirect = redirect_valid_in && (state_reg != MISALIGN);
  assign redirect_any  = trap_taken_in || take_redirect;
  assign mis_target    = !trap_taken_in && take_redirect && (redirect_addr_in[1:0] != 2'b00);
  assign target        = trap_taken_in ? {trap_vector_in[31:2], 2'b00} : redirect_addr_in;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= BOOT_ADDRESS;
      req_reg        <= 1'b0;
      addr_reg       <= BOOT_ADDRESS;
      instr_reg      <= NOP;
      pc_reg         <= BOOT_ADDRESS;
      valid_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
      buf_valid_reg  <= 1'b0;
      buf_instr_reg  <= NOP;
      buf_pc_reg     <= BOOT_ADDRESS;
      kill_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      req_reg        <= req_next;
      addr_reg       <= addr_next;
      instr_reg      <= instr_next;
      pc_reg         <= pc_next;
      valid_reg      <= valid_next;
      misaligned_reg <= misaligned_next;
      buf_valid_reg  <= buf_valid_next;
      buf_instr_reg  <= buf_instr_next;
      buf_pc_reg     <= buf_pc_next;
      kill_reg       <= kill_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    req_next        = req_reg;
    addr_next       = addr_reg;
    instr_next      = instr_reg;
    pc_next         = pc_reg;
    valid_next      = valid_reg;
    misaligned_next = 1'b0;
    buf_valid_next  = buf_valid_reg;
    buf_instr_next  = buf_instr_reg;
    buf_pc_next     = buf_pc_reg;
    kill_next       = kill_reg;
    go_block        = 1'b0;

    if (redirect_any) begin
      fetch_pc_next  = target;
      valid_next     = 1'b0;
      buf_valid_next = 1'b0;
      if (mis_target) begin
        misaligned_next = 1'b1;
        pc_next         = redirect_addr_in;
        state_next      = MISALIGN;
      end else begin
        state_next = REQ;
      end
      // The bus request must stay stable until its ack, so a pending one is left
      // running and its data thrown away; an ack arriving right now is simply ignored.
      if (req_reg && !imem_ack_in) begin
        kill_next = 1'b1;
      end else begin
        kill_next = 1'b0;
        req_next  = !mis_target;
        addr_next = target;
      end
    end else if (kill_reg) begin
      if (ack_fire) begin
        kill_next = 1'b0;
        req_next  = (state_reg == REQ);
        addr_next = fetch_pc_reg;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = REQ;
          req_next   = 1'b1;
          addr_next  = fetch_pc_reg;
        end

        REQ: begin
          if (consume) begin
            valid_next = 1'b0;
          end
          if (ack_fire) begin
            fetch_pc_next = pc_plus4;
            if (!valid_reg || !stall_in) begin
              instr_next = imem_rdata_in;
              pc_next    = addr_reg;
              valid_next = 1'b1;
              go_block   = stall_in;
            end else begin
              buf_valid_next = 1'b1;
              buf_instr_next = imem_rdata_in;
              buf_pc_next    = addr_reg;
              go_block       = 1'b1;
            end
            if (go_block) begin
              state_next = BLOCK;
              req_next   = 1'b0;
            end else begin
              req_next  = 1'b1;
              addr_next = pc_plus4;
            end
          end else if (!req_reg) begin
            req_next  = 1'b1;
            addr_next = fetch_pc_reg;
          end
        end

        BLOCK: begin
          // Once the output frees up the buffered word moves forward, so fetching can resume.
          if (!valid_reg || !stall_in) begin
            if (buf_valid_reg) begin
              instr_next     = buf_instr_reg;
              pc_next        = buf_pc_reg;
              valid_next     = 1'b1;
              buf_valid_next = 1'b0;
            end else begin
              valid_next = 1'b0;
            end
            state_next = REQ;
            req_next   = 1'b1;
            addr_next  = fetch_pc_reg;
          end
        end

        MISALIGN: begin
          req_next   = 1'b0;
          valid_next = 1'b0;
        end

        default: begin
          state_next = IDLE;
          req_next   = 1'b0;
        end
      endcase
    end
  end

  assign imem_req_out    = req_reg;
  assign imem_addr_out   = addr_reg;
  assign instr_out       = instr_reg;
  assign pc_out          = pc_reg;
  assign instr_valid_out = valid_reg;
  assign misaligned_out  = misaligned_reg;

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// Directed bench for msrv32_fetch_ctrl: a small imem responder with programmable wait
// states returns {16'hC0DE, addr[15:0]}, and each task checks one scenario cycle by cycle.
module tb_msrv32_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_addr_in;
  logic        trap_taken_in;
  logic [31:0] trap_vector_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_rdata_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid_out;
  logic        misaligned_out;

  int total = 0;
  int bad   = 0;
  int wait_cycles = 0;
  int cnt;

  msrv32_fetch_ctrl #(.BOOT_ADDRESS(32'h0000_0000)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .stall_in             (stall_in),
    .redirect_valid_in    (redirect_valid_in),
    .redirect_addr_in     (redirect_addr_in),
    .trap_taken_in        (trap_taken_in),
    .trap_vector_in       (trap_vector_in),
    .imem_req_out         (imem_req_out),
    .imem_addr_out        (imem_addr_out),
    .imem_ack_in          (imem_ack_in),
    .imem_rdata_in        (imem_rdata_in),
    .instr_out            (instr_out),
    .pc_out               (pc_out),
    .instr_valid_out      (instr_valid_out),
    .misaligned_out       (misaligned_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: counts cycles a request has been waiting, acks once wait_cycles have elapsed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (imem_req_out && !imem_ack_in) cnt <= cnt + 1;
    else cnt <= 0;
  end
  assign imem_ack_in   = imem_req_out && (cnt >= wait_cycles);
  assign imem_rdata_in = imem_ack_in ? {16'hC0DE, imem_addr_out[15:0]} : 32'hDEAD_BEEF;

  task automatic do_reset();
    rst_n = 1'b0;
    stall_in = 1'b0;
    redirect_valid_in = 1'b0;
    redirect_addr_in = 32'h0;
    trap_taken_in = 1'b0;
    trap_vector_in = 32'h0;
    wait_cycles = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall_in = 1'b0;
    redirect_valid_in = 1'b0;
    redirect_addr_in = 32'h0;
    trap_taken_in = 1'b0;
    trap_vector_in = 32'h0;
    repeat (2) @(negedge clk);
    total++; if (imem_req_out !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b want=0", imem_req_out); end
    total++; if (imem_addr_out !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", imem_addr_out); end
    total++; if (instr_out !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr got=%h want=00000013", instr_out); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", pc_out); end
    total++; if (instr_valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", instr_valid_out); end
    total++; if (misaligned_out !== 1'b0) begin bad++; $display("FAIL rst_mis got=%0b want=0", misaligned_out); end
    $display("reset: req=%0b addr=%h instr=%h pc=%h", imem_req_out, imem_addr_out, instr_out, pc_out);
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'(4 * k)) begin
        bad++; $display("FAIL zw_addr k=%0d got req=%0b addr=%h want req=1 addr=%h", k, imem_req_out, imem_addr_out, 32'(4 * k));
      end
      if (k > 0) begin
        exp_pc = 32'(4 * (k - 1));
        total++; if (instr_valid_out !== 1'b1 || pc_out !== exp_pc || instr_out !== {16'hC0DE, exp_pc[15:0]}) begin
          bad++; $display("FAIL zw_out k=%0d got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", k, instr_valid_out, pc_out, instr_out, exp_pc, {16'hC0DE, exp_pc[15:0]});
        end
      end
      $display("zero_wait k=%0d addr=%h v=%0b pc=%h instr=%h", k, imem_addr_out, instr_valid_out, pc_out, instr_out);
      @(negedge clk);
    end
  endtask

  task automatic test_wait_states();
    int pulses;
    do_reset();
    repeat (4) @(negedge clk);
    wait_cycles = 3;
    pulses = 0;
    for (int k = 4; k < 12; k++) begin
      if (k <= 7) begin
        total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h10) begin
          bad++; $display("FAIL ws_hold k=%0d got req=%0b addr=%h want req=1 addr=00000010", k, imem_req_out, imem_addr_out);
        end
      end
      if (k >= 5 && instr_valid_out === 1'b1) begin
        pulses++;
        total++; if (pc_out !== 32'h10) begin bad++; $display("FAIL ws_pc k=%0d got=%h want=00000010", k, pc_out); end
      end
      $display("wait_states k=%0d req=%0b addr=%h ack=%0b v=%0b pc=%h", k, imem_req_out, imem_addr_out, imem_ack_in, instr_valid_out, pc_out);
      @(negedge clk);
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL ws_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (2) @(negedge clk);
    total++; if (instr_valid_out !== 1'b1 || pc_out !== 32'h4) begin
      bad++; $display("FAIL st_pre got v=%0b pc=%h want v=1 pc=00000004", instr_valid_out, pc_out);
    end
    stall_in = 1'b1;
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      total++; if (imem_req_out !== 1'b0 || instr_valid_out !== 1'b1 || pc_out !== 32'h4) begin
        bad++; $display("FAIL st_hold k=%0d got req=%0b v=%0b pc=%h want req=0 v=1 pc=00000004", k, imem_req_out, instr_valid_out, pc_out);
      end
      $display("stall k=%0d req=%0b v=%0b pc=%h", k, imem_req_out, instr_valid_out, pc_out);
    end
    stall_in = 1'b0;
    @(negedge clk);
    total++; if (instr_valid_out !== 1'b1 || pc_out !== 32'h8 || instr_out !== 32'hC0DE_0008) begin
      bad++; $display("FAIL st_buf got v=%0b pc=%h instr=%h want v=1 pc=00000008 instr=c0de0008", instr_valid_out, pc_out, instr_out);
    end
    total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'hC) begin
      bad++; $display("FAIL st_resume got req=%0b addr=%h want req=1 addr=0000000c", imem_req_out, imem_addr_out);
    end
    $display("stall release: v=%0b pc=%h addr=%h", instr_valid_out, pc_out, imem_addr_out);
    @(negedge clk);
    total++; if (instr_valid_out !== 1'b1 || pc_out !== 32'hC) begin
      bad++; $display("FAIL st_next got v=%0b pc=%h want v=1 pc=0000000c", instr_valid_out, pc_out);
    end
    @(negedge clk);
    total++; if (instr_valid_out !== 1'b1 || pc_out !== 32'h10) begin
      bad++; $display("FAIL st_next2 got v=%0b pc=%h want v=1 pc=00000010", instr_valid_out, pc_out);
    end
    $display("stall after: v=%0b pc=%h", instr_valid_out, pc_out);
  endtask

  task automatic test_redirect_kill();
    do_reset();
    repeat (16) @(negedge clk);
    total++; if (imem_addr_out !== 32'h40) begin bad++; $display("FAIL rk_pre got=%h want=00000040", imem_addr_out); end
    wait_cycles = 2;
    @(negedge clk);
    redirect_valid_in = 1'b1;
    redirect_addr_in = 32'h200;
    @(negedge clk);
    redirect_valid_in = 1'b0;
    total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h40 || instr_valid_out !== 1'b0) begin
      bad++; $display("FAIL rk_hold got req=%0b addr=%h v=%0b want req=1 addr=00000040 v=0", imem_req_out, imem_addr_out, instr_valid_out);
    end
    wait_cycles = 0;
    @(negedge clk);
    total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h200 || instr_valid_out !== 1'b0) begin
      bad++; $display("FAIL rk_target got req=%0b addr=%h v=%0b want req=1 addr=00000200 v=0", imem_req_out, imem_addr_out, instr_valid_out);
    end
    @(negedge clk);
    total++; if (instr_valid_out !== 1'b1 || pc_out !== 32'h200 || instr_out !== 32'hC0DE_0200) begin
      bad++; $display("FAIL rk_out got v=%0b pc=%h instr=%h want v=1 pc=00000200 instr=c0de0200", instr_valid_out, pc_out, instr_out);
    end
    $display("redirect_kill: v=%0b pc=%h instr=%h", instr_valid_out, pc_out, instr_out);
  endtask

  task automatic test_trap_priority();
    do_reset();
    repeat (3) @(negedge clk);
    trap_taken_in = 1'b1;
    trap_vector_in = 32'h1003;
    redirect_valid_in = 1'b1;
    redirect_addr_in = 32'h300;
    @(negedge clk);
    trap_taken_in = 1'b0;
    redirect_valid_in = 1'b0;
    total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h1000 || instr_valid_out !== 1'b0 || misaligned_out !== 1'b0) begin
      bad++; $display("FAIL tp_addr got req=%0b addr=%h v=%0b mis=%0b want req=1 addr=00001000 v=0 mis=0", imem_req_out, imem_addr_out, instr_valid_out, misaligned_out);
    end
    @(negedge clk);
    total++; if (instr_valid_out !== 1'b1 || pc_out !== 32'h1000 || instr_out !== 32'hC0DE_1000) begin
      bad++; $display("FAIL tp_out got v=%0b pc=%h instr=%h want v=1 pc=00001000 instr=c0de1000", instr_valid_out, pc_out, instr_out);
    end
    $display("trap_priority: addr=%h pc=%h", imem_addr_out, pc_out);
  endtask

  task automatic test_misaligned();
    do_reset();
    repeat (2) @(negedge clk);
    redirect_valid_in = 1'b1;
    redirect_addr_in = 32'h202;
    @(negedge clk);
    redirect_valid_in = 1'b0;
    total++; if (misaligned_out !== 1'b1 || pc_out !== 32'h202 || instr_valid_out !== 1'b0 || imem_req_out !== 1'b0) begin
      bad++; $display("FAIL ma_pulse got mis=%0b pc=%h v=%0b req=%0b want mis=1 pc=00000202 v=0 req=0", misaligned_out, pc_out, instr_valid_out, imem_req_out);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (misaligned_out !== 1'b0 || imem_req_out !== 1'b0 || instr_valid_out !== 1'b0) begin
        bad++; $display("FAIL ma_park k=%0d got mis=%0b req=%0b v=%0b want all 0", k, misaligned_out, imem_req_out, instr_valid_out);
      end
    end
    trap_taken_in = 1'b1;
    trap_vector_in = 32'h100;
    @(negedge clk);
    trap_taken_in = 1'b0;
    total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h100) begin
      bad++; $display("FAIL ma_resume got req=%0b addr=%h want req=1 addr=00000100", imem_req_out, imem_addr_out);
    end
    @(negedge clk);
    total++; if (instr_valid_out !== 1'b1 || pc_out !== 32'h100 || instr_out !== 32'hC0DE_0100) begin
      bad++; $display("FAIL ma_out got v=%0b pc=%h instr=%h want v=1 pc=00000100 instr=c0de0100", instr_valid_out, pc_out, instr_out);
    end
    $display("misaligned: resumed pc=%h", pc_out);
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    redirect_valid_in = 1'b1;
    redirect_addr_in = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid_in = 1'b0;
    total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wr_addr got req=%0b addr=%h want req=1 addr=fffffffc", imem_req_out, imem_addr_out);
    end
    @(negedge clk);
    total++; if (imem_addr_out !== 32'h0 || instr_valid_out !== 1'b1 || pc_out !== 32'hFFFF_FFFC || instr_out !== 32'hC0DE_FFFC) begin
      bad++; $display("FAIL wr_next got addr=%h v=%0b pc=%h instr=%h want addr=0 v=1 pc=fffffffc instr=c0defffc", imem_addr_out, instr_valid_out, pc_out, instr_out);
    end
    $display("wrap: addr=%h pc=%h", imem_addr_out, pc_out);
  endtask

  task automatic test_reset_midway();
    do_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (imem_req_out !== 1'b0 || imem_addr_out !== 32'h0 || instr_valid_out !== 1'b0) begin
      bad++; $display("FAIL rm_bus got req=%0b addr=%h v=%0b want req=0 addr=0 v=0", imem_req_out, imem_addr_out, instr_valid_out);
    end
    total++; if (instr_out !== 32'h0000_0013 || pc_out !== 32'h0 || misaligned_out !== 1'b0) begin
      bad++; $display("FAIL rm_out got instr=%h pc=%h mis=%0b want instr=00000013 pc=0 mis=0", instr_out, pc_out, misaligned_out);
    end
    $display("reset_midway: req=%0b instr=%h", imem_req_out, instr_out);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_kill();
    test_trap_priority();
    test_misaligned();
    test_wrap();
    test_reset_midway();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
